// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a single-clock FIFO in front of a dual-port memory.
// Wrap-bit pointers give full/empty/count; request rejections are flagged one cycle later.
module fifo_ctrl #(
  parameter int unsigned DEEP      = 8,
  parameter int unsigned AF_MARGIN = 2,
  parameter int unsigned AE_MARGIN = 2
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            wr_req,
  input  logic            rd_req,
  output logic            w_en,
  output logic            r_en,
  output logic [DEEP-1:0] address_w,
  output logic [DEEP-1:0] address_r,
  output logic            rd_valid,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [DEEP:0]   count,
  output logic            wr_err,
  output logic            rd_err
);

  localparam int unsigned PW  = DEEP + 1;
  localparam int unsigned CAP = 1 << DEEP;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Occupancy and flags decode straight from the registered pointers.
  always_comb begin
    count        = wr_ptr - rd_ptr;
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[DEEP-1:0] == rd_ptr[DEEP-1:0]) && (wr_ptr[DEEP] != rd_ptr[DEEP]);
    almost_full  = (count >= PW'(CAP - AF_MARGIN));
    almost_empty = (count <= PW'(AE_MARGIN));
    address_w    = wr_ptr[DEEP-1:0];
    address_r    = rd_ptr[DEEP-1:0];
  end

  // Enables are sampled by the memory on the same edge that advances the pointers.
  assign w_en = wr_req & ~full  & ~rst;
  assign r_en = rd_req & ~empty & ~rst;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      if (w_en) wr_ptr <= wr_ptr + PW'(1);
      if (r_en) rd_ptr <= rd_ptr + PW'(1);
      rd_valid <= r_en;
      wr_err   <= wr_req & full;
      rd_err   <= rd_req & empty;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl (DEEP=3): directed plan scenarios then random traffic,
// checked against a queue-based occupancy/data model and a simple memory.
module tb_fifo_ctrl;

  localparam int unsigned DEEP = 3;
  localparam int unsigned CAP  = 8;

  logic            clk_in;
  logic            rst;
  logic            wr_req;
  logic            rd_req;
  logic            w_en;
  logic            r_en;
  logic [DEEP-1:0] address_w;
  logic [DEEP-1:0] address_r;
  logic            rd_valid;
  logic            full;
  logic            empty;
  logic            almost_full;
  logic            almost_empty;
  logic [DEEP:0]   count;
  logic            wr_err;
  logic            rd_err;

  fifo_ctrl #(.DEEP(DEEP), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
    .clk_in(clk_in), .rst(rst), .wr_req(wr_req), .rd_req(rd_req),
    .w_en(w_en), .r_en(r_en), .address_w(address_w), .address_r(address_r),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .wr_err(wr_err), .rd_err(rd_err)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Dual-port memory with registered read port, driven by the controller.
  logic [7:0] mem [CAP];
  logic [7:0] data_o;
  logic [7:0] wdata;
  always @(posedge clk_in) begin
    if (w_en) mem[address_w] <= wdata;
    if (r_en) data_o <= mem[address_r];
  end

  // Reference model: a queue of stored words plus total accepted operations.
  byte unsigned q[$];
  int  wr_total, rd_total;
  bit  known;
  bit  exp_rd_valid, exp_wr_err, exp_rd_err;
  byte unsigned exp_data;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_cycle(input bit rs, input bit w, input bit r, input byte unsigned d);
    bit was_full, was_empty, acc_w, acc_r;
    rst = rs; wr_req = w; rd_req = r; wdata = d;
    #1;
    was_full  = known && (q.size() == CAP);
    was_empty = known && (q.size() == 0);
    acc_w = !rs && w && !was_full;
    acc_r = !rs && r && !was_empty;
    chk("w_en", 32'(w_en), 32'(acc_w));
    chk("r_en", 32'(r_en), 32'(acc_r));
    if (known && !rs) begin
      chk("address_w", 32'(address_w), 32'(wr_total % CAP));
      chk("address_r", 32'(address_r), 32'(rd_total % CAP));
    end
    @(posedge clk_in);
    if (rs) begin
      q.delete();
      wr_total = 0; rd_total = 0;
      exp_rd_valid = 1'b0; exp_wr_err = 1'b0; exp_rd_err = 1'b0;
      known = 1'b1;
    end else begin
      exp_wr_err   = w && was_full;
      exp_rd_err   = r && was_empty;
      exp_rd_valid = acc_r;
      if (acc_r) begin
        exp_data = q.pop_front();
        rd_total++;
      end
      if (acc_w) begin
        q.push_back(d);
        wr_total++;
      end
    end
    @(negedge clk_in);
    chk("count",        32'(count),        32'(q.size()));
    chk("empty",        32'(empty),        32'(q.size() == 0));
    chk("full",         32'(full),         32'(q.size() == CAP));
    chk("almost_full",  32'(almost_full),  32'(q.size() >= CAP - 2));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
    chk("rd_valid",     32'(rd_valid),     32'(exp_rd_valid));
    chk("wr_err",       32'(wr_err),       32'(exp_wr_err));
    chk("rd_err",       32'(rd_err),       32'(exp_rd_err));
    chk("address_w_post", 32'(address_w),  32'(wr_total % CAP));
    chk("address_r_post", 32'(address_r),  32'(rd_total % CAP));
    if (exp_rd_valid) chk("data_o", 32'(data_o), 32'(exp_data));
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wdata = 8'h00;
    known = 1'b0; wr_total = 0; rd_total = 0;
    exp_rd_valid = 1'b0; exp_wr_err = 1'b0; exp_rd_err = 1'b0; exp_data = 8'h00;
    @(negedge clk_in);

    // Reset held two cycles with both requests high.
    do_cycle(1, 1, 1, 8'hFF);
    do_cycle(1, 1, 1, 8'hFF);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);

    // Fill with A0..A7, then a rejected 9th write.
    for (int i = 0; i < 8; i++) do_cycle(0, 1, 0, 8'(8'hA0 + i));
    do_cycle(0, 1, 0, 8'hEE);
    chk("fill_addr_w", 32'(address_w), 32'd0);
    do_cycle(0, 0, 0, 8'h00);

    // Drain in order, then a rejected 9th read.
    for (int i = 0; i < 8; i++) do_cycle(0, 0, 1, 8'h00);
    do_cycle(0, 0, 1, 8'h00);
    do_cycle(0, 0, 0, 8'h00);

    // Simultaneous requests at full and at empty.
    for (int i = 0; i < 8; i++) do_cycle(0, 1, 0, 8'(8'h10 + i));
    do_cycle(0, 1, 1, 8'h77);
    chk("full_both_count", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) do_cycle(0, 0, 1, 8'h00);
    do_cycle(0, 1, 1, 8'h33);
    chk("empty_both_count", 32'(count), 32'd1);
    do_cycle(0, 0, 1, 8'h00);

    // Streaming at count 4 across address wrap.
    for (int i = 0; i < 4; i++) do_cycle(0, 1, 0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) do_cycle(0, 1, 1, 8'(8'h50 + i));
    chk("stream_count", 32'(count), 32'd4);

    // Mid-operation reset at count 5, then 0x5C round-trip from address 0.
    do_cycle(0, 1, 0, 8'h99);
    do_cycle(1, 1, 1, 8'h00);
    chk("midrst_count", 32'(count), 32'd0);
    do_cycle(0, 1, 0, 8'h5C);
    do_cycle(0, 0, 1, 8'h00);
    chk("midrst_data", 32'(data_o), 32'h5C);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      do_cycle(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
